// File: rtl/dmem_ring.sv
// dmem_ring: DEPTH x DATABITS sample store with circular head pointer, tap reads relative to newest sample, full-array scan chain.
// Latency: writes/pushes/clear land at the clock edge; d_out is combinational, or one cycle late when DMEM_RDREG_EN is defined.
// Backpressure: none; one command per cycle is always accepted. Scan enable overrides commands; reset overrides everything.
module dmem_ring #(
  parameter int DATABITS = 16,
  parameter int DEPTH    = 8,
  parameter int ADDRW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sde_in,
  input  logic                sd_in,
  output logic                sd_out,
  input  logic [2:0]          cmd_in,
  input  logic [ADDRW-1:0]    addr_in,
  input  logic [DATABITS-1:0] d_in,
  output logic [DATABITS-1:0] d_out,
  output logic [ADDRW-1:0]    head_out,
  output logic                err_out
);

  localparam int NBITS = DEPTH * DATABITS;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_PUSH  = 3'b011;
  localparam logic [2:0] CMD_TAP   = 3'b100;
  localparam logic [2:0] CMD_CLEAR = 3'b101;

  localparam logic [ADDRW:0]        DEPTH_W   = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW-1:0]      HEAD_LAST = ADDRW'(DEPTH - 1);
  // Modular add of DEPTH; the bit pattern is what matters, even if it reads as negative.
  localparam logic signed [ADDRW:0] DEPTH_S   = (ADDRW + 1)'(DEPTH);
  localparam logic signed [ADDRW:0] ONE_S     = (ADDRW + 1)'(1);

  logic [DATABITS-1:0] mem_q [DEPTH];
  logic [DATABITS-1:0] mem_d [DEPTH];
  logic [ADDRW-1:0]    head_q, head_d;
  logic                err_q, err_d;
  logic                addr_ok;
  logic signed [ADDRW:0] tap_s;
  logic [ADDRW-1:0]    tap_idx;
  logic [NBITS-1:0]    flat_q, flat_sh;
  logic [DATABITS-1:0] rd_sel;

  // Non-power-of-two depths leave holes in the address space that must be flagged.
  assign addr_ok = ({1'b0, addr_in} < DEPTH_W);

  // Tap slot = (head - 1 - k) mod DEPTH; range of head-1-k fits ADDRW+1 signed bits.
  always_comb begin
    tap_s = $signed({1'b0, head_q}) - $signed({1'b0, addr_in}) - ONE_S;
    if (tap_s[ADDRW]) tap_s = tap_s + DEPTH_S;
    if (tap_s[ADDRW]) tap_s = tap_s + DEPTH_S;
    tap_idx = tap_s[ADDRW-1:0];
  end

  // Flatten the array for the scan chain; word DEPTH-1 MSB is the chain output.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      flat_q[i*DATABITS +: DATABITS] = mem_q[i];
    end
    flat_sh = {flat_q[NBITS-2:0], sd_in};
  end

  assign sd_out = flat_q[NBITS-1];

  // Next-state for memory, head pointer and error pulse.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    err_d  = 1'b0;
    if (sde_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = flat_sh[i*DATABITS +: DATABITS];
      end
    end else begin
      case (cmd_in)
        CMD_NOP: ;
        CMD_READ, CMD_TAP: err_d = !addr_ok;
        CMD_WRITE: begin
          if (addr_ok) mem_d[addr_in] = d_in;
          else         err_d = 1'b1;
        end
        CMD_PUSH: begin
          mem_d[head_q] = d_in;
          head_d = (head_q == HEAD_LAST) ? '0 : head_q + ADDRW'(1);
        end
        CMD_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
          head_d = '0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Read-data selection; zero unless a legal READ/TAP is presented outside scan.
  always_comb begin
    rd_sel = '0;
    if (!sde_in && addr_ok) begin
      if (cmd_in == CMD_READ)     rd_sel = mem_q[addr_in];
      else if (cmd_in == CMD_TAP) rd_sel = mem_q[tap_idx];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      err_q  <= err_d;
    end
  end

  assign head_out = head_q;
  assign err_out  = err_q;

`ifdef DMEM_RDREG_EN
  logic [DATABITS-1:0] dout_q;

  // Registered read port: loads the selection every edge, zero for non-read cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= rd_sel;
  end

  assign d_out = dout_q;
`else
  assign d_out = rd_sel;
`endif

endmodule

// File: tb/tb_dmem_ring.sv
// Bench for dmem_ring (DEPTH=5, DATABITS=16): directed test-plan sequences plus random traffic,
// checked every cycle against a word-array model of the delay line, with literal pins on key results.
module tb_dmem_ring;
  localparam int W  = 16;
  localparam int D  = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, sde_in, sd_in, sd_out, err_out;
  logic [2:0]    cmd_in;
  logic [AW-1:0] addr_in, head_out;
  logic [W-1:0]  d_in, d_out;

  int checks = 0;
  int errors = 0;

  dmem_ring #(.DATABITS(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sde_in(sde_in), .sd_in(sd_in), .sd_out(sd_out),
    .cmd_in(cmd_in), .addr_in(addr_in), .d_in(d_in), .d_out(d_out),
    .head_out(head_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] mem_m [D];
  int           head_m;
  bit           err_m;
  logic [W-1:0] dreg_m;
  bit           mvalid = 1'b0;
  logic [W-1:0] s_t;
  bit           e_t;
  bit           carry;
  logic [W-1:0] wtmp;

  function automatic logic [W-1:0] sel_m();
    int a;
    a = int'(addr_in);
    if (sde_in || a >= D) return '0;
    if (cmd_in == 3'd1) return mem_m[a];
    if (cmd_in == 3'd4) return mem_m[((head_m - 1 - a) % D + D) % D];
    return '0;
  endfunction

  function automatic bit bad_m();
    if (sde_in) return 1'b0;
    if (cmd_in >= 3'd6) return 1'b1;
    if ((cmd_in == 3'd1 || cmd_in == 3'd2 || cmd_in == 3'd4) && int'(addr_in) >= D) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_m[i] = '0;
      head_m = 0;
      err_m  = 1'b0;
      dreg_m = '0;
      mvalid = 1'b1;
    end else begin
      s_t = sel_m();
      e_t = bad_m();
      if (sde_in) begin
        carry = sd_in;
        for (int i = 0; i < D; i++) begin
          wtmp     = mem_m[i];
          mem_m[i] = {wtmp[W-2:0], carry};
          carry    = wtmp[W-1];
        end
      end else begin
        case (cmd_in)
          3'd2: if (int'(addr_in) < D) mem_m[int'(addr_in)] = d_in;
          3'd3: begin mem_m[head_m] = d_in; head_m = (head_m + 1) % D; end
          3'd5: begin for (int i = 0; i < D; i++) mem_m[i] = '0; head_m = 0; end
          default: ;
        endcase
      end
      err_m  = e_t;
      dreg_m = s_t;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("head_out", 32'(head_out), 32'(head_m));
      chk("err_out", 32'(err_out), 32'(err_m));
      chk("sd_out", 32'(sd_out), 32'(mem_m[D-1][W-1]));
`ifdef DMEM_RDREG_EN
      chk("d_out", 32'(d_out), 32'(dreg_m));
`else
      chk("d_out", 32'(d_out), 32'(sel_m()));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit r, input bit s, input bit sdi, input logic [2:0] c,
                     input int a, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    rst_n = r; sde_in = s; sd_in = sdi; cmd_in = c; addr_in = a[AW-1:0]; d_in = d;
  endtask

  task automatic op(input logic [2:0] c, input int a, input logic [W-1:0] d);
    drv(1'b1, 1'b0, 1'b0, c, a, d);
  endtask

  initial begin
    rst_n = 1'b0; sde_in = 1'b0; sd_in = 1'b0; cmd_in = '0; addr_in = '0; d_in = '0;
    drv(0, 0, 0, 3'd0, 0, 0);
    drv(0, 0, 0, 3'd0, 0, 0);
    #1 chk("rst_head", 32'(head_out), 0);
    chk("rst_err", 32'(err_out), 0);
    chk("rst_dout", 32'(d_out), 0);

    // three pushes, taps relative to newest
    op(3'd3, 0, 16'h0011); op(3'd3, 0, 16'h0022); op(3'd3, 0, 16'h0033);
    op(3'd4, 0, 0);
    #1 chk("push_head", 32'(head_out), 3);
`ifndef DMEM_RDREG_EN
    chk("tap0", 32'(d_out), 32'h33);
    op(3'd4, 1, 0); #1 chk("tap1", 32'(d_out), 32'h22);
    op(3'd4, 2, 0); #1 chk("tap2", 32'(d_out), 32'h11);
    op(3'd4, 3, 0); #1 chk("tap3", 32'(d_out), 32'h0);
`endif

    // wrap-around
    op(3'd5, 0, 0);
    for (int i = 1; i <= 7; i++) op(3'd3, 0, W'(i));
    op(3'd4, 0, 0);
    #1 chk("wrap_head", 32'(head_out), 2);
`ifndef DMEM_RDREG_EN
    chk("wrap_tap0", 32'(d_out), 7);
    for (int k = 1; k < 5; k++) begin
      op(3'd4, k, 0);
      #1 chk("wrap_tap", 32'(d_out), 32'(7 - k));
    end
    op(3'd1, 0, 0); #1 chk("wrap_read0", 32'(d_out), 6);
`endif

    // write/read, bad address, illegal opcode
    op(3'd2, 4, 16'hBEEF);
    op(3'd1, 4, 0);
`ifndef DMEM_RDREG_EN
    #1 chk("read4", 32'(d_out), 32'hBEEF);
    op(3'd1, 5, 0); #1 chk("read5_dout", 32'(d_out), 0);
`else
    op(3'd1, 5, 0);
`endif
    op(3'd0, 0, 0); #1 chk("read5_err", 32'(err_out), 1);
    op(3'd0, 0, 0); #1 chk("err_one_cycle", 32'(err_out), 0);
    op(3'd7, 0, 0);
    op(3'd0, 0, 0); #1 chk("illegal_err", 32'(err_out), 1);
    chk("illegal_head", 32'(head_out), 2);

    // scan out a written pattern, shifting ones in behind it
    for (int a = 0; a < D; a++) op(3'd2, a, W'($urandom));
    for (int i = 0; i < D * W + 10; i++) drv(1, 1, 1, 3'd3, 0, 16'h1234);
    #1 chk("scan_ones", 32'(sd_out), 1);
    chk("scan_head", 32'(head_out), 2);
    op(3'd1, 0, 0);
`ifndef DMEM_RDREG_EN
    #1 chk("scan_word0", 32'(d_out), 32'hFFFF);
`endif

    // clear after pushes
    op(3'd3, 0, 16'h5555); op(3'd3, 0, 16'h6666); op(3'd5, 0, 0);
    op(3'd0, 0, 0); #1 chk("clear_head", 32'(head_out), 0);
    for (int a = 0; a < D; a++) op(3'd1, a, 0);

    // reset during scan
    for (int a = 0; a < D; a++) op(3'd2, a, 16'hA5A5);
    drv(1, 1, 1, 3'd0, 0, 0); drv(1, 1, 0, 3'd0, 0, 0);
    drv(0, 1, 1, 3'd2, 1, 16'hFFFF);
    op(3'd1, 0, 0);
    #1 chk("rst_scan_sd", 32'(sd_out), 0);
`ifndef DMEM_RDREG_EN
    chk("rst_scan_word0", 32'(d_out), 0);
`endif

`ifdef DMEM_RDREG_EN
    op(3'd3, 0, 16'h00AA);
    op(3'd4, 0, 0); #1 chk("rdreg_tap_cycle", 32'(d_out), 0);
    op(3'd0, 0, 0); #1 chk("rdreg_tap_next", 32'(d_out), 32'hAA);
`endif

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      bit r, s;
      logic [2:0] c;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      if (c == 3'd5 && $urandom_range(0, 3) != 0) c = 3'd4;
      drv(r, s, 1'($urandom), c, int'($urandom_range(0, 7)), W'($urandom));
    end

    op(3'd0, 0, 0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_ring.md
# dmem_ring

Parametrised successor of the filter data memory: a DEPTH x DATABITS register-file sample store with a built-in circular delay-line head pointer, tap addressing relative to the newest sample, and a full-memory scan chain. It sits between the filter input stage and the MAC datapath. The input stage PUSHes samples, the controller TAP-reads x[n-k] without doing pointer arithmetic, and test access shifts the whole array serially.

## Interface
- DATABITS, 16: word width (>=1)
- DEPTH, 8: number of words (>=2, need not be a power of two)
- ADDRW, $clog2(DEPTH): derived address width; not to be overridden
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- sde_in  in  1  scan enable; overrides cmd_in
- sd_in  in  1  scan data in
- sd_out  out  1  scan data out
- cmd_in  in  3  command: 000 NOP, 001 READ, 010 WRITE, 011 PUSH, 100 TAP, 101 CLEAR, 110/111 illegal
- addr_in  in  ADDRW  physical address (READ/WRITE) or tap index k (TAP)
- d_in  in  DATABITS  write/push data
- d_out  out  DATABITS  read data
- head_out  out  ADDRW  current head pointer (next PUSH slot)
- err_out  out  1  one-cycle error pulse

## Operation
- State: mem_r[DEPTH][DATABITS], head (ADDRW bits, range 0..DEPTH-1), err_out register.
- Reset (rst_n=0 at clock edge): all mem_r=0, head=0, err_out=0, d_out=0 (registered variant). Reset wins over sde_in and every command.
- sde_in=1: mem_r viewed as a flat vector {mem_r[DEPTH-1],...,mem_r[0]}, MSB first. It shifts left by one with sd_in entering mem_r[0][0]. head is held, cmd_in is ignored, err_out=0. sd_out = mem_r[DEPTH-1][DATABITS-1] at all times.
- sde_in=0, per cmd_in:
  - NOP: no state change.
  - READ: d_out selects mem_r[addr_in].
  - WRITE: mem_r[addr_in] <= d_in.
  - PUSH: mem_r[head] <= d_in; head <= (head==DEPTH-1) ? 0 : head+1. addr_in is ignored.
  - TAP: d_out selects mem_r[p] with p = (head-1-k) mod DEPTH, k=addr_in. Compute on ADDRW+1 signed bits and add DEPTH if negative (twice if needed). TAP 0 is the newest sample.
  - CLEAR: all mem_r <= 0, head <= 0.
  - Illegal opcode: treated as NOP, err_out=1 for the next cycle.
- addr_in >= DEPTH on READ/WRITE/TAP: no write, d_out selects 0, err_out=1 for the next cycle.
- With no READ/TAP in progress, d_out selects 0.
- Contents outside a written slot are unchanged on every WRITE/PUSH. mem_r is stable on NOP/READ/TAP.

## Timing
- WRITE/PUSH/CLEAR take effect at the clock edge and are visible to READ/TAP in the next cycle. A same-cycle READ sees pre-write contents, which cannot happen because there is one command per cycle.
- d_out latency is 0 cycles (combinational from cmd_in/addr_in/mem_r/head) unless DMEM_RDREG_EN is defined.
- err_out asserts in the cycle after the offending command, for exactly one cycle.
- head_out is a register output and changes one edge after PUSH/CLEAR.
- Scan: after DEPTH*DATABITS shift cycles, the original flat vector has fully appeared on sd_out, MSB first.
- Asserting reset mid-scan or mid-sequence discards everything in progress and returns to the reset state.

## Configuration
- DMEM_RDREG_EN defined: d_out is a register loaded every edge with the selected value. READ/TAP data appear one cycle after the command, d_out is 0 after reset, and d_out loads 0 during scan and after any non-read command.
- DMEM_RDREG_EN undefined: d_out is combinational with 0-cycle latency.
- err_out timing is identical in both builds.

## Test plan
- Reset then PUSH 0x0011, 0x0022, 0x0033 (DEPTH=5) -> head_out=3; TAP k=0,1,2 return 0x0033, 0x0022, 0x0011; TAP k=3 returns 0x0000.
- Wrap: 7 PUSHes of 1..7 with DEPTH=5 -> head_out=2; TAP k=0..4 return 7,6,5,4,3; READ addr 0 returns 6.
- WRITE addr 4 = 0xBEEF then READ addr 4 -> 0xBEEF. READ addr 5 (DEPTH=5) -> d_out=0 and err_out pulses one cycle. cmd 3'b111 -> err_out pulse with no state change.
- Scan: load a known pattern by WRITE, hold sde_in=1 with sd_in=1 for DEPTH*DATABITS cycles -> sd_out reproduces the pattern MSB first, then all-ones; head_out is unchanged throughout.
- CLEAR after pushes -> all READs return 0 and head_out=0. Reset asserted during a scan shift -> mem_r=0 at the next edge.
- With DMEM_RDREG_EN: PUSH 0x00AA, then TAP 0 -> d_out=0x00AA one cycle after the TAP cycle and 0 in the TAP cycle itself.
